// File: rtl/alu_arbiter.sv
// Two-port sequencer/arbiter in front of a single registered ALU (one-cycle latency).
// Define ALU_ARB_RR_EN for round-robin arbitration; default build is fixed priority (port 0 wins).
module alu_arbiter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [2:0]        req0_aluc,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [2:0]        req1_aluc,
   output logic              req1_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_s,
   output logic              rsp0_zero,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_s,
   output logic              rsp1_zero,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_aluc,
   input  logic [DATA_W-1:0] alu_s,
   input  logic              alu_zero,
   output logic [1:0]        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high
   // and rst is low; the sender holds valid and payload stable until that edge.
   typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

   state_t state, state_nxt;
   logic   owner;
   logic   grant;
   logic   any_req;
   logic   accept;
   logic   rsp_take;

`ifdef ALU_ARB_RR_EN
   logic last_grant;

   always_comb begin
      grant = req0_valid ? 1'b0 : 1'b1;
      if (req0_valid && req1_valid)
         grant = ~last_grant;
   end
`else
   always_comb begin
      grant = req0_valid ? 1'b0 : 1'b1;
   end
`endif

   assign any_req   = req0_valid | req1_valid;
   assign dbg_state = state;

   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept     = 1'b0;
      rsp_take   = 1'b0;
      case (state)
         IDLE: begin
            if (any_req && !rst) begin
               accept     = 1'b1;
               req0_ready = ~grant;
               req1_ready = grant;
               state_nxt  = EXEC;
            end
         end
         EXEC: state_nxt = CAPT;
         CAPT: state_nxt = RESP;
         RESP: begin
            rsp_take = owner ? rsp1_ready : rsp0_ready;
            if (rsp_take)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_aluc   <= 3'b010;
         rsp0_valid <= 1'b0;
         rsp0_s     <= '0;
         rsp0_zero  <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_s     <= '0;
         rsp1_zero  <= 1'b0;
`ifdef ALU_ARB_RR_EN
         last_grant <= 1'b1;
`endif
      end else begin
         state <= state_nxt;
         if (accept) begin
            owner    <= grant;
            alu_a    <= grant ? req1_a    : req0_a;
            alu_b    <= grant ? req1_b    : req0_b;
            alu_aluc <= grant ? req1_aluc : req0_aluc;
`ifdef ALU_ARB_RR_EN
            last_grant <= grant;
`endif
         end
         // The ALU output is only meaningful in CAPT; it free-runs otherwise.
         if (state == CAPT) begin
            if (owner) begin
               rsp1_valid <= 1'b1;
               rsp1_s     <= alu_s;
               rsp1_zero  <= alu_zero;
            end else begin
               rsp0_valid <= 1'b1;
               rsp0_s     <= alu_s;
               rsp0_zero  <= alu_zero;
            end
         end
         if (rsp_take) begin
            if (owner)
               rsp1_valid <= 1'b0;
            else
               rsp0_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, arbitration/backpressure/reset
// sequences, and randomized traffic checked by a transaction-level scoreboard.
module tb_alu_arbiter;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0_valid = 0, req1_valid = 0;
   logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic [2:0]   req0_aluc = 0, req1_aluc = 0;
   logic         req0_ready, req1_ready;
   logic         rsp0_valid, rsp1_valid;
   logic [W-1:0] rsp0_s, rsp1_s;
   logic         rsp0_zero, rsp1_zero;
   logic         rsp0_ready = 1, rsp1_ready = 1;
   logic [W-1:0] alu_a, alu_b;
   logic [2:0]   alu_aluc;
   logic [W-1:0] alu_s = 32'hDEAD_BEEF;
   logic         alu_zero = 1'b1;
   logic [1:0]   dbg_state;

   int checks = 0;
   int errors = 0;
   bit rnd_done = 0;

   logic [W:0] exp0_q[$];
   logic [W:0] exp1_q[$];
   bit         grant_q[$];

   alu_arbiter #(.DATA_W(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
      .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp0_s(rsp0_s), .rsp0_zero(rsp0_zero), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_s(rsp1_s), .rsp1_zero(rsp1_zero), .rsp1_ready(rsp1_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
      .alu_s(alu_s), .alu_zero(alu_zero),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial forever #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference ALU behaviour from the opcode table.
   function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
      case (op)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b110:  return a - b;
         3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return a + b;
      endcase
   endfunction

   // Registered ALU with no reset, as seen by the arbiter.
   always @(posedge clk) begin
      alu_s    <= alu_ref(alu_a, alu_b, alu_aluc);
      alu_zero <= (alu_a == alu_b);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic rdy(input bit p);
      return p ? req1_ready : req0_ready;
   endfunction

   function automatic logic rv(input bit p);
      return p ? rsp1_valid : rsp0_valid;
   endfunction

   function automatic logic [W-1:0] rs(input bit p);
      return p ? rsp1_s : rsp0_s;
   endfunction

   function automatic logic rz(input bit p);
      return p ? rsp1_zero : rsp0_zero;
   endfunction

   // driver tasks
   task automatic set_req(input bit p, input logic v, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2:0] op);
      if (p == 1'b0) begin
         req0_valid = v; req0_a = a; req0_b = b; req0_aluc = op;
      end else begin
         req1_valid = v; req1_a = a; req1_b = b; req1_aluc = op;
      end
   endtask

   task automatic do_op(input bit p, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic [W-1:0] es, input logic ez,
                        input string nm);
      int cnt;
      int lat;
      @(negedge clk);
      set_req(p, 1'b1, a, b, op);
      #1;
      cnt = 0;
      while (!rdy(p) && cnt < 20) begin
         @(negedge clk); #1; cnt++;
      end
      chk({nm, " ready"}, rdy(p), 1);
      @(negedge clk);
      set_req(p, 1'b0, a, b, op);
      lat = 1;
      #1;
      while (!rv(p) && lat < 20) begin
         @(negedge clk); #1; lat++;
      end
      chk({nm, " latency"}, lat, 3);
      chk({nm, " s"}, rs(p), es);
      chk({nm, " zero"}, rz(p), ez);
      @(negedge clk); #1;
      chk({nm, " valid drop"}, rv(p), 0);
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, " req0_ready"}, req0_ready, 0);
      chk({nm, " req1_ready"}, req1_ready, 0);
      chk({nm, " rsp0_valid"}, rsp0_valid, 0);
      chk({nm, " rsp1_valid"}, rsp1_valid, 0);
      chk({nm, " rsp0_s"}, rsp0_s, 0);
      chk({nm, " rsp1_s"}, rsp1_s, 0);
      chk({nm, " rsp0_zero"}, rsp0_zero, 0);
      chk({nm, " rsp1_zero"}, rsp1_zero, 0);
      chk({nm, " alu_a"}, alu_a, 0);
      chk({nm, " alu_b"}, alu_b, 0);
      chk({nm, " alu_aluc"}, alu_aluc, 3'b010);
      chk({nm, " state"}, dbg_state, 0);
   endtask

   task automatic rnd_port(input bit p, input int n, input int gap);
      int cnt;
      repeat (n) begin
         repeat ($urandom_range(0, gap)) @(negedge clk);
         @(negedge clk);
         set_req(p, 1'b1, $urandom, ($urandom_range(0, 3) == 0) ? 32'h55 : $urandom,
                 3'($urandom_range(0, 7)));
         #1;
         cnt = 0;
         while (!rdy(p) && cnt < 300) begin
            @(negedge clk); #1; cnt++;
         end
         chk(p ? "rnd port1 grant timeout" : "rnd port0 grant timeout", cnt < 300, 1);
         @(negedge clk);
         set_req(p, 1'b0, 0, 0, 0);
      end
   endtask

   // scoreboard: handshakes sampled mid-cycle, after the drivers have settled
   always begin
      @(negedge clk);
      #2;
      if (rst) begin
         exp0_q.delete();
         exp1_q.delete();
      end else begin
         chk("ready one-hot", req0_ready & req1_ready, 0);
         if (req0_valid && req0_ready) begin
            exp0_q.push_back({req0_a == req0_b, alu_ref(req0_a, req0_b, req0_aluc)});
            grant_q.push_back(1'b0);
         end
         if (req1_valid && req1_ready) begin
            exp1_q.push_back({req1_a == req1_b, alu_ref(req1_a, req1_b, req1_aluc)});
            grant_q.push_back(1'b1);
         end
         if (rsp0_valid && rsp0_ready) begin
            chk("rsp0 expected", exp0_q.size() > 0, 1);
            if (exp0_q.size() > 0) chk("rsp0 sb", {rsp0_zero, rsp0_s}, exp0_q.pop_front());
         end
         if (rsp1_valid && rsp1_ready) begin
            chk("rsp1 expected", exp1_q.size() > 0, 1);
            if (exp1_q.size() > 0) chk("rsp1 sb", {rsp1_zero, rsp1_s}, exp1_q.pop_front());
         end
      end
   end

   typedef struct {
      bit         port;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0] op;
      logic [W-1:0] s;
      logic       z;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int cnt;
      logic [W-1:0] held_s;
      bit exp_grants[5];

      vecs[0] = '{0, 32'd5,      32'd7,      3'b010, 32'd12,         1'b0};
      vecs[1] = '{1, 32'h1234,   32'h1234,   3'b110, 32'd0,          1'b1};
      vecs[2] = '{1, 32'd3,      32'd9,      3'b111, 32'd1,          1'b0};
      vecs[3] = '{1, 32'd9,      32'd3,      3'b111, 32'd0,          1'b0};
      vecs[4] = '{0, 32'hF0,     32'h3C,     3'b000, 32'h30,         1'b0};
      vecs[5] = '{1, 32'hF0,     32'h0F,     3'b001, 32'hFF,         1'b0};
      vecs[6] = '{0, 32'd2,      32'd3,      3'b011, 32'd5,          1'b0};
      vecs[7] = '{0, 32'd3,      32'd5,      3'b110, 32'hFFFF_FFFE,  1'b0};
      vecs[8] = '{1, 32'hFFFF_FFFF, 32'd1,   3'b111, 32'd1,          1'b0};
      vecs[9] = '{0, 32'hFFFF_FFFF, 32'd1,   3'b010, 32'd0,          1'b0};

      // reset
      repeat (3) @(negedge clk);
      #1;
      check_reset_vals("reset");
      rst = 0;

      // directed vectors
      for (int i = 0; i < 10; i++)
         do_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].s, vecs[i].z,
               $sformatf("vec%0d", i));

      // contention: both ports valid every cycle, starting from reset history
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
      grant_q.delete();
`ifdef ALU_ARB_RR_EN
      exp_grants = '{0, 1, 0, 1, 1};
`else
      exp_grants = '{0, 0, 0, 0, 1};
`endif
      set_req(0, 1'b1, 32'd1, 32'd1, 3'b010);
      set_req(1, 1'b1, 32'd2, 32'd2, 3'b010);
      cnt = 0;
      while (grant_q.size() < 4 && cnt < 100) begin
         @(negedge clk); #3; cnt++;
      end
      chk("contention 4 grants", grant_q.size() >= 4, 1);
      @(negedge clk);
      set_req(0, 1'b0, 0, 0, 0);
      cnt = 0;
      while (grant_q.size() < 5 && cnt < 100) begin
         @(negedge clk); #3; cnt++;
      end
      chk("contention 5th grant", grant_q.size() >= 5, 1);
      @(negedge clk);
      set_req(1, 1'b0, 0, 0, 0);
      for (int i = 0; i < 5; i++)
         if (i < grant_q.size()) chk($sformatf("grant%0d", i), grant_q[i], exp_grants[i]);
      repeat (6) @(negedge clk);

      // backpressure on port 0 with port 1 waiting
      rsp0_ready = 0;
      set_req(0, 1'b1, 32'd40, 32'd2, 3'b010);
      #1;
      cnt = 0;
      while (!req0_ready && cnt < 20) begin
         @(negedge clk); #1; cnt++;
      end
      chk("bp accept", req0_ready, 1);
      @(negedge clk);
      set_req(0, 1'b0, 0, 0, 0);
      set_req(1, 1'b1, 32'd8, 32'd8, 3'b110);
      cnt = 0;
      #1;
      while (!rsp0_valid && cnt < 20) begin
         @(negedge clk); #1; cnt++;
      end
      chk("bp rsp0_valid", rsp0_valid, 1);
      held_s = rsp0_s;
      chk("bp rsp0_s", held_s, 32'd42);
      repeat (6) begin
         @(negedge clk); #1;
         chk("bp hold valid", rsp0_valid, 1);
         chk("bp hold s", rsp0_s, held_s);
         chk("bp req1 blocked", req1_ready, 0);
         chk("bp state RESP", dbg_state, 3);
      end
      rsp0_ready = 1;
      @(negedge clk); #1;
      chk("bp released", rsp0_valid, 0);
      chk("bp req1 granted", req1_ready, 1);
      @(negedge clk);
      set_req(1, 1'b0, 0, 0, 0);
      repeat (6) @(negedge clk);

      // reset while in CAPT
      set_req(0, 1'b1, 32'd1, 32'd2, 3'b010);
      #1;
      cnt = 0;
      while (!req0_ready && cnt < 20) begin
         @(negedge clk); #1; cnt++;
      end
      @(negedge clk);
      set_req(0, 1'b0, 0, 0, 0);
      @(negedge clk); #1;
      chk("rst state CAPT", dbg_state, 2);
      rst = 1;
      @(negedge clk); #1;
      check_reset_vals("rst in CAPT");
      rst = 0;
      repeat (4) begin
         @(negedge clk); #1;
         chk("no rsp after rst", rsp0_valid | rsp1_valid, 0);
      end
      do_op(0, 32'hF0, 32'h3C, 3'b000, 32'h30, 1'b0, "post-rst AND");

      // randomized traffic
      fork
         begin
            fork
               rnd_port(0, 30, 8);
               rnd_port(1, 30, 3);
            join
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               @(negedge clk);
               rsp0_ready = ($urandom_range(0, 3) != 0);
               rsp1_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      rsp0_ready = 1;
      rsp1_ready = 1;
      repeat (20) @(negedge clk);
      chk("exp0_q drained", exp0_q.size(), 0);
      chk("exp1_q drained", exp1_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
